// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing one FIFO write port between N_REQ producers,
// with FIFO-full back-pressure and a per-grant burst limit of MAX_BURST beats.
module fifo_wr_arbiter #(
    parameter int N_REQ     = 4,
    parameter int D_WIDTH   = 8,
    parameter int MAX_BURST = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [N_REQ-1:0]         req,
    input  logic [N_REQ*D_WIDTH-1:0] req_data,
    output logic [N_REQ-1:0]         req_ready,
    input  logic                     fifo_full,
    output logic                     fifo_w_en,
    output logic [D_WIDTH-1:0]       fifo_w_data,
    output logic [N_REQ-1:0]         grant,
    output logic                     busy
);
    localparam int PTR_W = $clog2(N_REQ);
    localparam int CNT_W = $clog2(MAX_BURST + 1);

    typedef enum logic {ST_IDLE, ST_GRANT} state_t;

    state_t             r_state;
    state_t             w_nxt_state;
    logic [N_REQ-1:0]   r_grant;
    logic [N_REQ-1:0]   w_nxt_grant;
    logic [PTR_W-1:0]   r_rr_ptr;
    logic [PTR_W-1:0]   w_nxt_rr_ptr;
    logic [CNT_W-1:0]   r_beat_cnt;
    logic [CNT_W-1:0]   w_nxt_beat_cnt;
    logic [PTR_W-1:0]   w_owner;
    logic [PTR_W-1:0]   w_owner_nxt;
    logic               w_owner_req;
    logic               w_last_beat;

    // First set bit of mask scanning upward from ptr, wrapping to 0.
    function automatic logic [N_REQ-1:0] f_pick(input logic [N_REQ-1:0] mask,
                                                input logic [PTR_W-1:0] ptr);
        logic [N_REQ-1:0] pick;
        logic             found;
        pick  = '0;
        found = 1'b0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            if (!found && (i >= 32'(ptr)) && mask[i]) begin
                pick[i] = 1'b1;
                found   = 1'b1;
            end
        end
        for (int unsigned i = 0; i < N_REQ; i++) begin
            if (!found && (i < 32'(ptr)) && mask[i]) begin
                pick[i] = 1'b1;
                found   = 1'b1;
            end
        end
        return pick;
    endfunction

    assign grant     = r_grant;
    assign busy      = (r_state == ST_GRANT);
    assign req_ready = r_grant & {N_REQ{~fifo_full}};
    assign fifo_w_en = |(req & req_ready);

    always_comb begin
        fifo_w_data = '0;
        w_owner     = '0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            if (r_grant[i]) begin
                fifo_w_data = fifo_w_data | req_data[i*D_WIDTH +: D_WIDTH];
                w_owner     = PTR_W'(i);
            end
        end
    end

    assign w_owner_nxt = (w_owner == PTR_W'(N_REQ - 1)) ? '0 : w_owner + PTR_W'(1);
    assign w_owner_req = |(req & r_grant);
    assign w_last_beat = fifo_w_en && (r_beat_cnt == CNT_W'(MAX_BURST - 1));

    always_comb begin
        w_nxt_state    = r_state;
        w_nxt_grant    = r_grant;
        w_nxt_rr_ptr   = r_rr_ptr;
        w_nxt_beat_cnt = r_beat_cnt;
        case (r_state)
            ST_IDLE: begin
                w_nxt_grant    = '0;
                w_nxt_beat_cnt = '0;
                if (|req) begin
                    w_nxt_grant = f_pick(req, r_rr_ptr);
                    w_nxt_state = ST_GRANT;
                end
            end
            ST_GRANT: begin
                if (!w_owner_req || w_last_beat) begin
                    // Scanning from owner+1 visits the old owner last, so masking it
                    // only matters when it is the sole requester, where regrant is allowed.
                    w_nxt_rr_ptr   = w_owner_nxt;
                    w_nxt_grant    = f_pick(req, w_owner_nxt);
                    w_nxt_beat_cnt = '0;
                    w_nxt_state    = (|req) ? ST_GRANT : ST_IDLE;
                end else if (fifo_w_en) begin
                    w_nxt_beat_cnt = r_beat_cnt + CNT_W'(1);
                end
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_grant    <= '0;
            r_rr_ptr   <= '0;
            r_beat_cnt <= '0;
        end else begin
            r_state    <= w_nxt_state;
            r_grant    <= w_nxt_grant;
            r_rr_ptr   <= w_nxt_rr_ptr;
            r_beat_cnt <= w_nxt_beat_cnt;
        end
    end

endmodule
